// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write, dual read, lock requests and registered read results.
// The master modport drives requests; the slave modport (the register file) returns results.
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] data_in;
  logic [ADDR_WIDTH-1:0] writenum;
  logic                  write;
  logic [ADDR_WIDTH-1:0] readnum_a;
  logic [ADDR_WIDTH-1:0] readnum_b;
  logic                  read_en;
  logic                  lock_en;
  logic [ADDR_WIDTH-1:0] lock_num;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  valid_out;
  logic                  busy_a;
  logic                  busy_b;
  logic [NUM_REGS-1:0]   busy_mask;

  modport master (
    output data_in, writenum, write, readnum_a, readnum_b, read_en, lock_en, lock_num,
    input  data_a, data_b, valid_out, busy_a, busy_b, busy_mask
  );

  modport slave (
    input  data_in, writenum, write, readnum_a, readnum_b, read_en, lock_en, lock_num,
    output data_a, data_b, valid_out, busy_a, busy_b, busy_mask
  );
endinterface

// File: rtl/regfile_mp.sv
// Dual-read, single-write register file with write-first bypass and a busy scoreboard
// that marks registers with a pending write (lock) until they are written.
module regfile_mp #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter bit ZERO_REG   = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  regfile_mp_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_mask_reg;
  logic [NUM_REGS-1:0]   busy_mask_next;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [NUM_REGS-1:0]   lock_hit;
  logic [NUM_REGS-1:0]   busy_seen;

  logic [DATA_WIDTH-1:0] data_a_reg, data_a_next;
  logic [DATA_WIDTH-1:0] data_b_reg, data_b_next;
  logic                  busy_a_reg, busy_a_next;
  logic                  busy_b_reg, busy_b_next;
  logic                  valid_reg;

  // Per-register decode; addresses past NUM_REGS match nothing and are ignored.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_decode
      localparam bit WRITABLE = (ZERO_REG == 1'b0) || (gi != 0);
      assign wr_hit[gi]   = WRITABLE && bus.write   && (bus.writenum == ADDR_WIDTH'(gi));
      assign lock_hit[gi] = WRITABLE && bus.lock_en && (bus.lock_num == ADDR_WIDTH'(gi));
    end
  endgenerate

  // Reads observe the write-clear of this cycle but not the lock-set; lock wins on a tie.
  assign busy_seen      = busy_mask_reg & ~wr_hit;
  assign busy_mask_next = busy_seen | lock_hit;

  always_comb begin
    data_a_next = '0;
    data_b_next = '0;
    busy_a_next = 1'b0;
    busy_b_next = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.readnum_a == ADDR_WIDTH'(i)) begin
        data_a_next = wr_hit[i] ? bus.data_in : regs_reg[i];
        busy_a_next = busy_seen[i];
      end
      if (bus.readnum_b == ADDR_WIDTH'(i)) begin
        data_b_next = wr_hit[i] ? bus.data_in : regs_reg[i];
        busy_b_next = busy_seen[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
      busy_mask_reg <= '0;
      data_a_reg    <= '0;
      data_b_reg    <= '0;
      busy_a_reg    <= 1'b0;
      busy_b_reg    <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) begin
          regs_reg[i] <= bus.data_in;
        end
      end
      busy_mask_reg <= busy_mask_next;
      valid_reg     <= bus.read_en;
      if (bus.read_en) begin
        data_a_reg <= data_a_next;
        data_b_reg <= data_b_next;
        busy_a_reg <= busy_a_next;
        busy_b_reg <= busy_b_next;
      end
    end
  end

  assign bus.data_a    = data_a_reg;
  assign bus.data_b    = data_b_reg;
  assign bus.busy_a    = busy_a_reg;
  assign bus.busy_b    = busy_b_reg;
  assign bus.valid_out = valid_reg;
  assign bus.busy_mask = busy_mask_reg;
endmodule
